// File: rtl/writeback_buffer_if.sv
// Writeback buffer bus: completed-instruction input group, retire/commit ports,
// register lookup and occupancy. The DUT binds the slave modport.
interface writeback_buffer_if #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [LANES-1:0]        in_valid;
  logic                    in_ready;
  logic [LANES-1:0][4:0]   in_dest_addr;
  logic [LANES-1:0]        in_write_enable;
  logic [LANES-1:0][63:0]  in_write_data;
  logic [LANES-1:0][31:0]  in_inst;
  logic [LANES-1:0][63:0]  in_pc;

  logic [WPORTS-1:0]       reg_write_enable;
  logic [WPORTS-1:0][4:0]  reg_dest_addr;
  logic [WPORTS-1:0][63:0] reg_write_data;
  logic [WPORTS-1:0]       commit_valid;
  logic [WPORTS-1:0][31:0] commit_inst;
  logic [WPORTS-1:0][63:0] commit_pc;

  logic [4:0]              query_addr;
  logic                    query_hit;
  logic [63:0]             query_data;
  logic [CW-1:0]           count;

  modport master (
    output in_valid, in_dest_addr, in_write_enable, in_write_data, in_inst, in_pc, query_addr,
    input  in_ready, reg_write_enable, reg_dest_addr, reg_write_data,
           commit_valid, commit_inst, commit_pc, query_hit, query_data, count
  );

  modport slave (
    input  in_valid, in_dest_addr, in_write_enable, in_write_data, in_inst, in_pc, query_addr,
    output in_ready, reg_write_enable, reg_dest_addr, reg_write_data,
           commit_valid, commit_inst, commit_pc, query_hit, query_data, count
  );
endinterface

// File: rtl/writeback_buffer.sv
// Multi-lane in-order writeback FIFO with youngest-match register lookup.
// Optional WB_BYPASS_EN: same-cycle retire of the oldest lanes into an empty buffer.

// Packs one input lane into a buffer entry; x0 writes lose their enable here.
module writeback_buffer_lane (
  input  logic [4:0]   dest_addr,
  input  logic         write_enable,
  input  logic [63:0]  write_data,
  input  logic [31:0]  inst,
  input  logic [63:0]  pc,
  output logic [165:0] entry
);
  assign entry = {write_enable && (dest_addr != 5'd0), dest_addr, write_data, inst, pc};
endmodule

module writeback_buffer #(
  parameter int LANES  = 2,
  parameter int WPORTS = 1,
  parameter int DEPTH  = 4
) (
  input logic             clk,
  input logic             reset,
  writeback_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] inst;
    logic [63:0] pc;
  } entry_t;

  entry_t                   mem [DEPTH];
  logic [PW-1:0]            head, tail;
  logic [CW-1:0]            count;

  logic [LANES-1:0][165:0]  lane_raw;
  int                       rank [LANES];
  int                       n_val, n_byp, n_enq, n_ret;
  logic                     in_ready_w, accept;
  entry_t [WPORTS-1:0]      port_e;
  logic [WPORTS-1:0]        port_v;
  entry_t                   q_e;
  logic                     q_hit;
  logic [63:0]              q_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    writeback_buffer_lane u_lane (
      .dest_addr    (bus.in_dest_addr[g]),
      .write_enable (bus.in_write_enable[g]),
      .write_data   (bus.in_write_data[g]),
      .inst         (bus.in_inst[g]),
      .pc           (bus.in_pc[g]),
      .entry        (lane_raw[g])
    );
  end

  // Ready depends on registered occupancy only, never on same-cycle retires.
  assign in_ready_w = (CW'(DEPTH) - count) >= CW'(LANES);
  assign accept     = in_ready_w && (|bus.in_valid);
  assign n_ret      = (int'(count) < WPORTS) ? int'(count) : WPORTS;

  // rank[i] = number of valid lanes older than lane i (its packing offset).
  always_comb begin
    n_val = 0;
    for (int i = 0; i < LANES; i++) begin
      rank[i] = n_val;
      if (bus.in_valid[i]) n_val = n_val + 1;
    end
`ifdef WB_BYPASS_EN
    n_byp = (accept && count == '0) ? ((n_val < WPORTS) ? n_val : WPORTS) : 0;
`else
    n_byp = 0;
`endif
    n_enq = accept ? (n_val - n_byp) : 0;
  end

  // Bypass only fires on an empty buffer, so FIFO retire and bypass never share a port.
  always_comb begin
    port_e = '0;
    port_v = '0;
    for (int p = 0; p < WPORTS; p++) begin
      if (p < n_ret) begin
        port_e[p] = mem[head + PW'(p)];
        port_v[p] = 1'b1;
      end else if (p < n_byp) begin
        for (int i = 0; i < LANES; i++) begin
          if (bus.in_valid[i] && rank[i] == p) begin
            port_e[p] = entry_t'(lane_raw[i]);
            port_v[p] = 1'b1;
          end
        end
      end
    end
  end

  for (genvar p = 0; p < WPORTS; p++) begin : g_port
    assign bus.commit_valid[p]     = port_v[p];
    assign bus.reg_write_enable[p] = port_e[p].wen;
    assign bus.reg_dest_addr[p]    = port_e[p].rd;
    assign bus.reg_write_data[p]   = port_e[p].data;
    assign bus.commit_inst[p]      = port_e[p].inst;
    assign bus.commit_pc[p]        = port_e[p].pc;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    q_e    = '0;
    q_hit  = 1'b0;
    q_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      q_e = mem[head + PW'(k)];
      if (k < int'(count) && q_e.wen && q_e.rd == bus.query_addr && bus.query_addr != 5'd0) begin
        q_hit  = 1'b1;
        q_data = q_e.data;
      end
    end
  end

  assign bus.query_hit  = q_hit;
  assign bus.query_data = q_data;
  assign bus.in_ready   = in_ready_w;
  assign bus.count      = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(n_ret);
      tail  <= tail + PW'(n_enq);
      count <= count + CW'(n_enq) - CW'(n_ret);
    end
  end

  // Payload RAM has no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.in_valid[i] && rank[i] >= n_byp)
          mem[tail + PW'(rank[i] - n_byp)] <= entry_t'(lane_raw[i]);
      end
    end
  end
endmodule
